// File: rtl/wptr_full_ctrl.sv
//==============================================================================
// Module      : wptr_full_ctrl
// Description : Write-side pointer and full-flag controller for a dual-clock
//               FIFO. Keeps the binary write counter, publishes the Gray write
//               pointer to the read domain, and registers the full flag.
//               Also registers almost-full, a fill level and a sticky
//               overflow flag.
//               Optional feature macro: WPTR_FULL_LEVEL_EN. When it is
//               defined, the fill level and threshold-based almost-full are
//               built. When it is undefined, wlevel_o is 0 and
//               walmost_full_o follows wfull_o.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module wptr_full_ctrl #(
  parameter int ADDRSIZE     = 4,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                wclk_i,
  input  logic                wrst_i,
  input  logic                winc_i,
  input  logic [ADDRSIZE:0]   wq2_rptr_i,
  input  logic                wovf_clr_i,
  output logic [ADDRSIZE:0]   wptr_o,
  output logic [ADDRSIZE-1:0] waddr_o,
  output logic                wen_o,
  output logic                wfull_o,
  output logic                walmost_full_o,
  output logic [ADDRSIZE:0]   wlevel_o,
  output logic                woverflow_o
);

  logic [ADDRSIZE:0] wbin_q, wbin_d;
  logic [ADDRSIZE:0] wptr_q, wptr_d;
  logic              wfull_q, wfull_d;
  logic              woverflow_q, woverflow_d;
  logic              w_accept;
  logic [ADDRSIZE:0] w_full_pattern;

  // A write is taken only against the registered full flag, so a read that
  // frees space in the same cycle is seen one cycle later.
  assign w_accept = winc_i & ~wfull_q;

  // Next binary/Gray pointer and full detection against the read pointer
  // with its two MSBs inverted (same address, one lap ahead).
  always_comb begin
    wbin_d         = wbin_q + {{ADDRSIZE{1'b0}}, w_accept};
    wptr_d         = (wbin_d >> 1) ^ wbin_d;
    w_full_pattern = {~wq2_rptr_i[ADDRSIZE:ADDRSIZE-1], wq2_rptr_i[ADDRSIZE-2:0]};
    wfull_d        = (wptr_d == w_full_pattern);
  end

  // Sticky overflow: a write attempt while full sets it, and set beats clear.
  always_comb begin
    woverflow_d = woverflow_q;
    if (winc_i & wfull_q) begin
      woverflow_d = 1'b1;
    end else if (wovf_clr_i) begin
      woverflow_d = 1'b0;
    end
  end

  // Pointer, full and overflow registers.
  always_ff @(posedge wclk_i) begin
    if (wrst_i) begin
      wbin_q      <= '0;
      wptr_q      <= '0;
      wfull_q     <= 1'b0;
      woverflow_q <= 1'b0;
    end else begin
      wbin_q      <= wbin_d;
      wptr_q      <= wptr_d;
      wfull_q     <= wfull_d;
      woverflow_q <= woverflow_d;
    end
  end

`ifdef WPTR_FULL_LEVEL_EN
  localparam int                AFULL_THRESH_INT = (1 << ADDRSIZE) - AFULL_MARGIN;
  localparam logic [ADDRSIZE:0] c_afull_thresh   = AFULL_THRESH_INT[ADDRSIZE:0];

  logic [ADDRSIZE:0] rbin_s;
  logic [ADDRSIZE:0] wlevel_q, wlevel_d;
  logic              walmost_full_q, walmost_full_d;

  // Gray-to-binary of the read pointer: each binary bit is the parity of
  // the Gray bits from that position up to the MSB.
  always_comb begin
    rbin_s = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      rbin_s[i] = ^(wq2_rptr_i >> i);
    end
  end

  // Fill level after this edge's write, and the almost-full threshold test.
  always_comb begin
    wlevel_d       = wbin_d - rbin_s;
    walmost_full_d = (wlevel_d >= c_afull_thresh);
  end

  // Level and almost-full registers.
  always_ff @(posedge wclk_i) begin
    if (wrst_i) begin
      wlevel_q       <= '0;
      walmost_full_q <= 1'b0;
    end else begin
      wlevel_q       <= wlevel_d;
      walmost_full_q <= walmost_full_d;
    end
  end

  assign wlevel_o       = wlevel_q;
  assign walmost_full_o = walmost_full_q;
`else
  assign wlevel_o       = '0;
  assign walmost_full_o = wfull_q;
`endif

  assign wptr_o      = wptr_q;
  assign waddr_o     = wbin_q[ADDRSIZE-1:0];
  assign wen_o       = w_accept;
  assign wfull_o     = wfull_q;
  assign woverflow_o = woverflow_q;

endmodule

`default_nettype wire
